// File: rtl/ioctl_upload_ram.sv
// ioctl_upload_ram: serves game work-RAM bytes to the HPS over the ioctl upload
// channel (high-score / NVRAM save). The game is frozen through a hold
// request/acknowledge handshake for the whole session so the RAM reads coherent.
// Optional feature: define UPLOAD_CHKSUM_EN to return the two's complement of the
// session byte sum when the HPS reads address DEPTH.
module ioctl_upload_ram #(
   parameter int AW      = 17,
   parameter int RAW     = 11,
   parameter int DEPTH   = 2048,
   parameter int RAM_LAT = 1,
   parameter int HOLD_TO = 65535
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           ioctl_upload,
   input  logic           ioctl_rd,
   input  logic [AW-1:0]  ioctl_addr,
   output logic [7:0]     ioctl_din,
   output logic           ioctl_wait,
   output logic           hold_req,
   input  logic           hold_ack,
   output logic [RAW-1:0] ram_addr,
   output logic           ram_rd,
   input  logic [7:0]     ram_q
);

   typedef enum logic [2:0] {IDLE, HOLD, READY, FETCH, RELEASE} state_t;

   localparam logic [16:0]   TO_LIMIT = 17'(HOLD_TO);
   localparam logic [AW-1:0] DEPTH_A  = AW'(DEPTH);
   localparam logic [2:0]    LAT      = 3'(RAM_LAT);

   state_t        state;
   logic          upload_q;
   logic          degraded;
   logic          pend;
   logic [AW-1:0] pend_addr;
   logic [15:0]   to_cnt;
   logic [2:0]    lat_cnt;

   logic          up_rise;
   logic          up_fall;
   logic          req_valid;
   logic [AW-1:0] req_addr;
   logic [7:0]    oor_data;

`ifdef UPLOAD_CHKSUM_EN
   logic [7:0]    chk_sum;
`endif

   // Session edges, and the read request seen in READY: a fresh strobe wins over
   // one latched while the game was still being frozen.
   always_comb begin
      up_rise   = ioctl_upload & ~upload_q;
      up_fall   = ~ioctl_upload & upload_q;
      req_valid = ioctl_rd | pend;
      req_addr  = ioctl_rd ? ioctl_addr : pend_addr;
`ifdef UPLOAD_CHKSUM_EN
      oor_data  = (req_addr == DEPTH_A && !degraded) ? (8'h00 - chk_sum) : 8'hFF;
`else
      oor_data  = 8'hFF;
`endif
   end

   // Session FSM: freeze the game, serve reads from RAM, release on session end.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         upload_q   <= 1'b0;
         degraded   <= 1'b0;
         pend       <= 1'b0;
         pend_addr  <= '0;
         to_cnt     <= '0;
         lat_cnt    <= '0;
         ioctl_din  <= 8'hFF;
         ioctl_wait <= 1'b0;
         hold_req   <= 1'b0;
         ram_addr   <= '0;
         ram_rd     <= 1'b0;
`ifdef UPLOAD_CHKSUM_EN
         chk_sum    <= '0;
`endif
      end else begin
         upload_q <= ioctl_upload;
         ram_rd   <= 1'b0;
         if (up_fall && state != RELEASE) begin
            state      <= RELEASE;
            hold_req   <= 1'b0;
            ioctl_wait <= 1'b0;
            pend       <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (up_rise) begin
                     state      <= HOLD;
                     hold_req   <= 1'b1;
                     ioctl_wait <= 1'b1;
                     to_cnt     <= '0;
                     pend       <= 1'b0;
                  end
               end
               HOLD: begin
                  if (ioctl_rd) begin
                     pend      <= 1'b1;
                     pend_addr <= ioctl_addr;
                  end
                  if (to_cnt != 16'hFFFF) begin
                     to_cnt <= to_cnt + 16'd1;
                  end
                  if (hold_ack) begin
                     state      <= READY;
                     ioctl_wait <= ioctl_rd | pend;
                  end else if (({1'b0, to_cnt} + 17'd1) >= TO_LIMIT) begin
                     state      <= READY;
                     degraded   <= 1'b1;
                     ioctl_wait <= ioctl_rd | pend;
                  end
               end
               READY: begin
                  pend <= 1'b0;
                  if (req_valid) begin
                     if (!degraded && req_addr < DEPTH_A) begin
                        state      <= FETCH;
                        ram_addr   <= req_addr[RAW-1:0];
                        ram_rd     <= 1'b1;
                        ioctl_wait <= 1'b1;
                        lat_cnt    <= '0;
                     end else begin
                        ioctl_din  <= oor_data;
                        ioctl_wait <= 1'b0;
                     end
                  end
               end
               FETCH: begin
                  if (lat_cnt == LAT) begin
                     ioctl_din  <= ram_q;
                     ioctl_wait <= 1'b0;
                     state      <= READY;
`ifdef UPLOAD_CHKSUM_EN
                     chk_sum    <= chk_sum + ram_q;
`endif
                  end else begin
                     lat_cnt <= lat_cnt + 3'd1;
                  end
               end
               RELEASE: begin
                  state      <= IDLE;
                  degraded   <= 1'b0;
                  hold_req   <= 1'b0;
                  ioctl_wait <= 1'b0;
`ifdef UPLOAD_CHKSUM_EN
                  chk_sum    <= '0;
`endif
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ioctl_upload_ram.sv
// tb_ioctl_upload_ram: two instances share clock and reset. Instance A uses
// RAM_LAT=1 with a long hold timeout; instance B uses RAM_LAT=4 and HOLD_TO=16.
// Expected read data is queued when a read is issued and popped on completion.
module tb_ioctl_upload_ram;

   localparam int DEPTH = 2048;

   logic        clk;
   logic        rst_n;

   logic        a_upload, a_rd, a_ack, a_wait, a_hreq, a_rrd;
   logic [16:0] a_addr;
   logic [7:0]  a_din, a_q;
   logic [10:0] a_raddr;

   logic        b_upload, b_rd, b_ack, b_wait, b_hreq, b_rrd;
   logic [16:0] b_addr;
   logic [7:0]  b_din, b_q;
   logic [10:0] b_raddr;

   logic [7:0]  mem_a [0:DEPTH-1];
   logic [7:0]  mem_b [0:DEPTH-1];
   logic [7:0]  a_pipe;
   logic [7:0]  b_pipe [0:3];
   int          a_rrd_cnt;
   int          b_rrd_cnt;

   logic [7:0]  exp_q [$];
   int          n_tests;
   int          n_fail;

   ioctl_upload_ram #(.RAM_LAT(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .ioctl_upload(a_upload), .ioctl_rd(a_rd),
      .ioctl_addr(a_addr), .ioctl_din(a_din), .ioctl_wait(a_wait),
      .hold_req(a_hreq), .hold_ack(a_ack), .ram_addr(a_raddr),
      .ram_rd(a_rrd), .ram_q(a_q)
   );

   ioctl_upload_ram #(.RAM_LAT(4), .HOLD_TO(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .ioctl_upload(b_upload), .ioctl_rd(b_rd),
      .ioctl_addr(b_addr), .ioctl_din(b_din), .ioctl_wait(b_wait),
      .hold_req(b_hreq), .hold_ack(b_ack), .ram_addr(b_raddr),
      .ram_rd(b_rrd), .ram_q(b_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM models: one registered stage for A, four for B; count read strobes.
   always @(posedge clk) begin
      if (a_rrd) a_pipe <= mem_a[a_raddr];
      if (b_rrd) b_pipe[0] <= mem_b[b_raddr];
      for (int i = 1; i < 4; i++) b_pipe[i] <= b_pipe[i-1];
      if (a_rrd) a_rrd_cnt <= a_rrd_cnt + 1;
      if (b_rrd) b_rrd_cnt <= b_rrd_cnt + 1;
   end
   assign a_q = a_pipe;
   assign b_q = b_pipe[3];

   // Global time limit so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] time limit");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one read strobe, then follow the instance until ioctl_wait is low.
   task automatic do_read(input bit sel, input logic [16:0] addr,
                          output logic [7:0] data, output int lat, output logic rrd1);
      if (sel) begin b_rd = 1'b1; b_addr = addr; end
      else begin a_rd = 1'b1; a_addr = addr; end
      tick();
      a_rd = 1'b0;
      b_rd = 1'b0;
      rrd1 = sel ? b_rrd : a_rrd;
      lat = -1;
      for (int k = 1; k <= 50; k++) begin
         if ((sel ? b_wait : a_wait) == 1'b0) begin
            lat = k;
            break;
         end
         tick();
      end
      data = sel ? b_din : a_din;
   endtask

   task automatic start_session(input bit sel, output int cycles);
      if (sel) b_upload = 1'b1; else a_upload = 1'b1;
      tick();
      cycles = -1;
      for (int k = 1; k <= 100; k++) begin
         if ((sel ? b_wait : a_wait) == 1'b0) begin
            cycles = k - 1;
            break;
         end
         tick();
      end
   endtask

   task automatic end_session(input bit sel);
      if (sel) b_upload = 1'b0; else a_upload = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      logic [7:0] ad [5];
      logic [7:0] ex [5];
      ad[0] = a_din; ad[1] = {7'd0, a_wait}; ad[2] = {7'd0, a_hreq};
      ad[3] = a_raddr[7:0]; ad[4] = {7'd0, a_rrd};
      ex[0] = 8'hFF; ex[1] = 8'h00; ex[2] = 8'h00; ex[3] = 8'h00; ex[4] = 8'h00;
      for (int i = 0; i < 5; i++) begin
         n_tests++;
         if (ad[i] !== ex[i]) begin
            n_fail++;
            $display("[TB] FAIL reset_a[%0d]: got %h expected %h", i, ad[i], ex[i]);
         end
      end
      n_tests++;
      if (b_din !== 8'hFF || b_wait !== 1'b0 || b_hreq !== 1'b0 || b_raddr !== 11'd0 || b_rrd !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_b: got din=%h wait=%b hreq=%b raddr=%h rrd=%b expected FF/0/0/0/0",
                  b_din, b_wait, b_hreq, b_raddr, b_rrd);
      end
   endtask

   task automatic test_basic_read();
      logic [7:0] d, e;
      int lat, cyc;
      logic r1;
      mem_a[5] = 8'h3C;
      a_ack = 1'b1;
      start_session(1'b0, cyc);
      n_tests++;
      if (cyc !== 1) begin
         n_fail++;
         $display("[TB] FAIL basic_hold_cycles: got %0d expected 1", cyc);
      end
      exp_q.push_back(mem_a[5]);
      do_read(1'b0, 17'd5, d, lat, r1);
      e = exp_q.pop_front();
      n_tests++;
      if (r1 !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL basic_ram_rd_t1: got %b expected 1", r1);
      end
      n_tests++;
      if (lat !== 3) begin
         n_fail++;
         $display("[TB] FAIL basic_latency: got %0d expected 3", lat);
      end
      n_tests++;
      if (d !== e) begin
         n_fail++;
         $display("[TB] FAIL basic_data: got %h expected %h", d, e);
      end
   endtask

   task automatic test_out_of_range();
      logic [7:0] d, e;
      int lat, cnt0;
      logic r1;
      cnt0 = a_rrd_cnt;
      exp_q.push_back(8'hFF);
      do_read(1'b0, 17'(DEPTH + 1), d, lat, r1);
      e = exp_q.pop_front();
      n_tests++;
      if (lat !== 1) begin
         n_fail++;
         $display("[TB] FAIL oor_latency: got %0d expected 1", lat);
      end
      n_tests++;
      if (d !== e) begin
         n_fail++;
         $display("[TB] FAIL oor_data: got %h expected %h", d, e);
      end
      n_tests++;
      if (a_rrd_cnt !== cnt0) begin
         n_fail++;
         $display("[TB] FAIL oor_ram_rd: got %0d strobes expected %0d", a_rrd_cnt, cnt0);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d, e;
      int lat;
      logic r1;
      logic [16:0] addr;
      for (int i = 0; i < 7; i++) begin
         addr = (i == 6) ? 17'h1FFFF : 17'($urandom_range(0, DEPTH - 1));
         exp_q.push_back((i == 6) ? 8'hFF : mem_a[addr[10:0]]);
         do_read(1'b0, addr, d, lat, r1);
         e = exp_q.pop_front();
         n_tests++;
         if (d !== e || lat !== ((i == 6) ? 1 : 3)) begin
            n_fail++;
            $display("[TB] FAIL b2b_read[%0d] addr %h: got %h lat %0d expected %h lat %0d",
                     i, addr, d, lat, e, (i == 6) ? 1 : 3);
         end
      end
   endtask

   task automatic test_checksum();
      logic [7:0] d, e;
      int lat, cyc;
      logic r1;
      end_session(1'b0);
      mem_a[0] = 8'h01; mem_a[1] = 8'h02; mem_a[2] = 8'h03;
      start_session(1'b0, cyc);
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(mem_a[i]);
         do_read(1'b0, 17'(i), d, lat, r1);
         e = exp_q.pop_front();
         n_tests++;
         if (d !== e) begin
            n_fail++;
            $display("[TB] FAIL chk_byte[%0d]: got %h expected %h", i, d, e);
         end
      end
`ifdef UPLOAD_CHKSUM_EN
      exp_q.push_back(8'hFA);
`else
      exp_q.push_back(8'hFF);
`endif
      do_read(1'b0, 17'(DEPTH), d, lat, r1);
      e = exp_q.pop_front();
      n_tests++;
      if (d !== e || lat !== 1) begin
         n_fail++;
         $display("[TB] FAIL chk_depth_read: got %h lat %0d expected %h lat 1", d, lat, e);
      end
      end_session(1'b0);
   endtask

   task automatic test_hold_handshake();
      logic [7:0] e;
      int wait_hi, hreq_lo, done_cyc;
      mem_a[0] = 8'h5A;
      exp_q.push_back(mem_a[0]);
      a_ack = 1'b0;
      a_upload = 1'b1;
      wait_hi = 0;
      hreq_lo = 0;
      done_cyc = -1;
      for (int c = 0; c < 60; c++) begin
         a_rd   = (c == 3);
         a_addr = 17'd0;
         a_ack  = (c >= 20);
         tick();
         a_rd = 1'b0;
         if (a_hreq !== 1'b1) hreq_lo++;
         if (a_wait === 1'b1) wait_hi++;
         else begin
            done_cyc = c + 1;
            break;
         end
      end
      e = exp_q.pop_front();
      n_tests++;
      if (done_cyc !== 24 || wait_hi !== 23) begin
         n_fail++;
         $display("[TB] FAIL hs_wait_span: got done %0d high %0d expected done 24 high 23", done_cyc, wait_hi);
      end
      n_tests++;
      if (a_din !== e) begin
         n_fail++;
         $display("[TB] FAIL hs_data: got %h expected %h", a_din, e);
      end
      tick();
      tick();
      if (a_hreq !== 1'b1) hreq_lo++;
      n_tests++;
      if (hreq_lo !== 0) begin
         n_fail++;
         $display("[TB] FAIL hs_hold_req_high: got %0d low cycles expected 0", hreq_lo);
      end
      a_upload = 1'b0;
      tick();
      n_tests++;
      if (a_hreq !== 1'b0 || a_wait !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL hs_release: got hreq=%b wait=%b expected 0/0", a_hreq, a_wait);
      end
      tick();
      a_ack = 1'b1;
   endtask

   task automatic test_timeout();
      logic [7:0] d;
      int lat, cyc, cnt0;
      logic r1;
      b_ack = 1'b0;
      start_session(1'b1, cyc);
      n_tests++;
      if (cyc !== 16) begin
         n_fail++;
         $display("[TB] FAIL to_cycles: got %0d expected 16", cyc);
      end
      cnt0 = b_rrd_cnt;
      exp_q.push_back(8'hFF);
      mem_b[0] = 8'h11;
      do_read(1'b1, 17'd0, d, lat, r1);
      n_tests++;
      if (d !== exp_q.pop_front() || lat !== 1) begin
         n_fail++;
         $display("[TB] FAIL to_degraded_read: got %h lat %0d expected ff lat 1", d, lat);
      end
      tick();
      n_tests++;
      if (b_rrd_cnt !== cnt0 || r1 !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL to_ram_rd: got %0d strobes expected %0d", b_rrd_cnt - cnt0, 0);
      end
      end_session(1'b1);
   endtask

   task automatic test_abort();
      logic [7:0] d, e;
      int lat, cyc;
      logic r1;
      mem_b[3] = 8'h33;
      mem_b[7] = 8'h77;
      b_ack = 1'b1;
      start_session(1'b1, cyc);
      exp_q.push_back(mem_b[3]);
      do_read(1'b1, 17'd3, d, lat, r1);
      e = exp_q.pop_front();
      n_tests++;
      if (d !== e || lat !== 6) begin
         n_fail++;
         $display("[TB] FAIL abort_first_read: got %h lat %0d expected %h lat 6", d, lat, e);
      end
      b_rd = 1'b1;
      b_addr = 17'd7;
      tick();
      b_rd = 1'b0;
      tick();
      b_upload = 1'b0;
      tick();
      n_tests++;
      if (b_hreq !== 1'b0 || b_wait !== 1'b0 || b_din !== e) begin
         n_fail++;
         $display("[TB] FAIL abort_release: got hreq=%b wait=%b din=%h expected 0/0/%h", b_hreq, b_wait, b_din, e);
      end
      for (int i = 0; i < 8; i++) tick();
      n_tests++;
      if (b_hreq !== 1'b0 || b_din !== e) begin
         n_fail++;
         $display("[TB] FAIL abort_idle: got hreq=%b din=%h expected 0/%h", b_hreq, b_din, e);
      end
   endtask

   task automatic test_reset_mid_hold();
      b_ack = 1'b0;
      b_upload = 1'b1;
      tick();
      tick();
      n_tests++;
      if (b_hreq !== 1'b1 || b_wait !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL rst_pre_hold: got hreq=%b wait=%b expected 1/1", b_hreq, b_wait);
      end
      rst_n = 1'b0;
      b_upload = 1'b0;
      tick();
      n_tests++;
      if (b_din !== 8'hFF || b_wait !== 1'b0 || b_hreq !== 1'b0 || b_raddr !== 11'd0 || b_rrd !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL rst_mid_hold: got din=%h wait=%b hreq=%b raddr=%h rrd=%b expected FF/0/0/0/0",
                  b_din, b_wait, b_hreq, b_raddr, b_rrd);
      end
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      n_tests = 0;
      n_fail = 0;
      a_rrd_cnt = 0;
      b_rrd_cnt = 0;
      a_pipe = 8'h00;
      for (int i = 0; i < 4; i++) b_pipe[i] = 8'h00;
      for (int i = 0; i < DEPTH; i++) begin
         mem_a[i] = 8'($urandom);
         mem_b[i] = 8'($urandom);
      end
      rst_n = 1'b0;
      a_upload = 1'b0; a_rd = 1'b0; a_addr = '0; a_ack = 1'b0;
      b_upload = 1'b0; b_rd = 1'b0; b_addr = '0; b_ack = 1'b0;
      tick();
      tick();
      test_reset();
      rst_n = 1'b1;
      tick();
      test_basic_read();
      test_out_of_range();
      test_back_to_back();
      test_checksum();
      test_hold_handshake();
      test_timeout();
      test_abort();
      test_reset_mid_hold();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
